// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped read-only cache controller.
// Holds the default address-field widths, the tag-width helper and the
// controller FSM state encoding used by cache_ctrl.
package cache_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int INDEX_W_DEF    = 6;
  localparam int WORD_OFF_W_DEF = 2;
  localparam int CNT_W_DEF      = 10;

  // Byte-in-word bits; requests are word aligned so these are ignored.
  localparam int BYTE_OFF_W = 2;

  // Whatever address bits are left above index and offsets form the tag.
  function automatic int tag_width(input int addr_w, input int index_w,
                                   input int word_off_w);
    return addr_w - index_w - word_off_w - BYTE_OFF_W;
  endfunction

  localparam int TAG_W = tag_width(ADDR_W_DEF, INDEX_W_DEF, WORD_OFF_W_DEF);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    REFILL   = 3'd3,
    RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/cache_data_bram.sv
// Cache data store: single-port, synchronous-read BRAM with a write enable.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable; wdata is written to addr on the clock edge
//   addr  - word address {index, word offset}
//   wdata - write data
//   rdata - registered read data for the address presented last cycle
module cache_data_bram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1<<AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, read-only cache controller. Looks up word reads from the
// core, returns hits from the data BRAM and refills whole lines from backing
// memory on a miss. Keeps saturating hit/miss statistics.
// Ports:
//   clk, rst                     - clock, asynchronous active-low reset
//   req_valid/req_addr/req_ready - core read request handshake
//   flush                        - invalidate all lines (honoured in IDLE only)
//   resp_valid/resp_data/resp_hit- one-cycle response pulse
//   mem_req_valid/addr/ready     - line fetch request to backing memory
//   mem_rvalid/mem_rdata         - refill beats, word order 0..N-1
//   hit_cnt/miss_cnt             - saturating statistics counters
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INDEX_W    = INDEX_W_DEF,
  parameter int WORD_OFF_W = WORD_OFF_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int LINE_TAG_W = tag_width(ADDR_W, INDEX_W, WORD_OFF_W);
  localparam int LINES      = 1 << INDEX_W;
  localparam int OFF_LO     = BYTE_OFF_W;
  localparam int IDX_LO     = OFF_LO + WORD_OFF_W;
  localparam int TAG_LO     = IDX_LO + INDEX_W;

  state_t state, next_state;

  logic [WORD_OFF_W-1:0] req_off;
  logic [INDEX_W-1:0]    req_index;
  logic [LINE_TAG_W-1:0] req_tag;
  logic [WORD_OFF_W-1:0] off_q;
  logic [INDEX_W-1:0]    index_q;
  logic [LINE_TAG_W-1:0] tag_q;
  logic [WORD_OFF_W-1:0] beat;
  logic [LINES-1:0]      valid;
  logic [LINE_TAG_W-1:0] tags [LINES];

  logic                          hit;
  logic                          last_beat;
  logic                          bram_we;
  logic [INDEX_W+WORD_OFF_W-1:0] bram_addr;
  logic [DATA_W-1:0]             bram_rdata;
  logic                          unused_byte_bits;

  assign req_off          = req_addr[IDX_LO-1:OFF_LO];
  assign req_index        = req_addr[TAG_LO-1:IDX_LO];
  assign req_tag          = req_addr[ADDR_W-1:TAG_LO];
  assign unused_byte_bits = ^req_addr[OFF_LO-1:0];

  assign hit       = valid[index_q] && (tags[index_q] == tag_q);
  assign last_beat = (beat == {WORD_OFF_W{1'b1}});

  cache_data_bram #(
    .AW(INDEX_W + WORD_OFF_W),
    .DW(DATA_W)
  ) u_bram (
    .clk  (clk),
    .we   (bram_we),
    .addr (bram_addr),
    .wdata(mem_rdata),
    .rdata(bram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The BRAM address follows the incoming request while idle so the read
  // data is already available in LOOKUP; during refill it tracks the beat.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = {req_index, req_off};
    case (state)
      IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        next_state = hit ? RESP : MISS_REQ;
      end
      MISS_REQ: begin
        if (mem_req_ready) begin
          next_state = REFILL;
        end
      end
      REFILL: begin
        bram_addr = {index_q, beat};
        bram_we   = mem_rvalid;
        if (mem_rvalid && last_beat) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs are loaded from next_state so that resp_valid and
  // mem_req_valid are high exactly while the FSM sits in RESP / MISS_REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_hit      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      valid         <= '0;
      beat          <= '0;
      off_q         <= '0;
      index_q       <= '0;
      tag_q         <= '0;
    end else begin
      resp_valid    <= (next_state == RESP);
      mem_req_valid <= (next_state == MISS_REQ);
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (req_valid) begin
            off_q   <= req_off;
            index_q <= req_index;
            tag_q   <= req_tag;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_data <= bram_rdata;
            resp_hit  <= 1'b1;
            if (!(&hit_cnt)) begin
              hit_cnt <= hit_cnt + CNT_W'(1);
            end
          end else begin
            mem_req_addr <= {tag_q, index_q, {(WORD_OFF_W + OFF_LO){1'b0}}};
            if (!(&miss_cnt)) begin
              miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            beat <= '0;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            beat <= beat + WORD_OFF_W'(1);
            if (beat == off_q) begin
              resp_data <= mem_rdata;
            end
            if (last_beat) begin
              valid[index_q] <= 1'b1;
              resp_hit       <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tags need no reset: a line's tag is only consulted when its valid bit
  // is set, and the valid bit is only set together with the tag write.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rvalid && last_beat) begin
      tags[index_q] <= tag_q;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios, a randomized
// phase with a behavioural cache model, and a reset-during-refill check.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [9:0]  hit_cnt;
  logic [9:0]  miss_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cycle_cnt   = 0;
  int last_beat_cnt = 0;
  int ready_delay = 0;
  int gap_max     = 0;
  int abort_after = 4;
  bit stray_en    = 1'b0;
  bit partial_done = 1'b0;

  logic [31:0] mem_override [logic [31:0]];

  // Behavioural model of the cache contents and statistics.
  bit          mvalid [64];
  logic [21:0] mtag   [64];
  int          mhit;
  int          mmiss;

  cache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_hit     (resp_hit),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [31:0] backing(input logic [31:0] a);
    if (mem_override.exists(a)) return mem_override[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 1023) ? 1023 : v + 1;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cycle_cnt);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = '0;
    end
    mhit  = 0;
    mmiss = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_resp_valid"},    32'(resp_valid),    32'd0);
    check_output({tag, "_resp_data"},     resp_data,          32'd0);
    check_output({tag, "_resp_hit"},      32'(resp_hit),      32'd0);
    check_output({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check_output({tag, "_mem_req_addr"},  mem_req_addr,       32'd0);
    check_output({tag, "_hit_cnt"},       32'(hit_cnt),       32'd0);
    check_output({tag, "_miss_cnt"},      32'(miss_cnt),      32'd0);
  endtask

  // Memory responder: grants the fetch after ready_delay cycles, then
  // delivers the line with random gaps. Optionally injects stray beats
  // when no refill is in flight, or stops early to exercise reset.
  initial begin : responder
    logic [31:0] line;
    int n;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      if (rst !== 1'b1) continue;
      if (mem_req_valid) begin
        repeat (ready_delay) @(negedge clk);
        mem_req_ready = 1'b1;
        line = mem_req_addr;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n = (abort_after < 4) ? abort_after : 4;
        for (int b = 0; b < n; b++) begin
          repeat ($urandom_range(gap_max, 0)) @(negedge clk);
          mem_rvalid    = 1'b1;
          mem_rdata     = backing(line + 32'(4 * b));
          last_beat_cnt = cycle_cnt;
          @(negedge clk);
          mem_rvalid = 1'b0;
        end
        if (n < 4) begin
          partial_done = 1'b1;
          wait (rst == 1'b0);
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hDEAD_BEEF;
          wait (rst == 1'b1);
          repeat (2) @(negedge clk);
          mem_rvalid = 1'b0;
        end
      end else if (stray_en && $urandom_range(7, 0) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end
    end
  end

  // One read transaction, checked cycle by cycle against the model.
  task automatic apply_stimulus(input logic [31:0] addr, input bit flush_mid,
                                output logic [31:0] got_data,
                                output logic got_hit,
                                output logic [31:0] got_mreq);
    logic [5:0]  idx;
    logic [21:0] tg;
    logic        exp_hit;
    logic [31:0] exp_data;
    logic [31:0] line;
    bit          done;
    int          hi_cycles;
    idx      = addr[9:4];
    tg       = addr[31:10];
    line     = {addr[31:4], 4'h0};
    exp_data = backing({addr[31:2], 2'b00});
    exp_hit  = mvalid[idx] && (mtag[idx] == tg);
    got_mreq = '0;
    got_data = '0;
    got_hit  = 1'b0;

    @(negedge clk);
    check_output("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = {addr[31:2], 2'($urandom_range(3, 0))};

    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    flush     = flush_mid;
    check_output("lookup_req_ready", 32'(req_ready), 32'd0);
    check_output("lookup_resp_valid", 32'(resp_valid), 32'd0);
    check_output("lookup_mem_req_valid", 32'(mem_req_valid), 32'd0);
    if (exp_hit) begin
      mhit = sat_inc(mhit);
    end else begin
      mmiss       = sat_inc(mmiss);
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end

    @(negedge clk);
    flush = 1'b0;
    check_output("hit_cnt", 32'(hit_cnt), 32'(mhit));
    check_output("miss_cnt", 32'(miss_cnt), 32'(mmiss));
    if (exp_hit) begin
      check_output("hit_resp_valid", 32'(resp_valid), 32'd1);
    end else begin
      check_output("miss_mem_req_valid", 32'(mem_req_valid), 32'd1);
      check_output("miss_mem_req_addr", mem_req_addr, line);
      check_output("miss_early_resp", 32'(resp_valid), 32'd0);
      got_mreq  = mem_req_addr;
      hi_cycles = 1;
      done      = 1'b0;
      for (int w = 0; w < 400 && !done; w++) begin
        @(negedge clk);
        if (resp_valid) begin
          done = 1'b1;
        end else begin
          check_output("busy_req_ready", 32'(req_ready), 32'd0);
          if (mem_req_valid) begin
            hi_cycles++;
            check_output("stable_mem_req_addr", mem_req_addr, line);
          end
        end
      end
      if (!done) begin
        check_output("resp_timeout", 32'(resp_valid), 32'd1);
        return;
      end
      check_output("mreq_hold_cycles", 32'(hi_cycles), 32'(ready_delay + 1));
      check_output("miss_resp_latency", 32'(cycle_cnt), 32'(last_beat_cnt + 1));
      check_output("resp_mem_req_valid", 32'(mem_req_valid), 32'd0);
    end
    check_output("resp_hit", 32'(resp_hit), 32'(exp_hit));
    check_output("resp_data", resp_data, exp_data);
    got_data = resp_data;
    got_hit  = resp_hit;

    @(negedge clk);
    check_output("post_resp_valid", 32'(resp_valid), 32'd0);
    check_output("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  // Flush in IDLE, optionally racing a request that must not be accepted.
  task automatic check_output_flush(input bit with_req, input logic [31:0] addr);
    @(negedge clk);
    flush     = 1'b1;
    req_valid = with_req;
    req_addr  = addr;
    #1;
    check_output("flush_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check_output("flush_not_accepted", 32'(req_ready), 32'd1);
    check_output("flush_no_mem_req", 32'(mem_req_valid), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d, expected completion", cycle_cnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] d;
    logic [31:0] m;
    logic        h;
    logic [31:0] a;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    model_reset();
    mem_override[32'h10]  = 32'hA0;
    mem_override[32'h14]  = 32'hA1;
    mem_override[32'h18]  = 32'hA2;
    mem_override[32'h1C]  = 32'hA3;
    mem_override[32'h410] = 32'hB0;
    mem_override[32'h414] = 32'hB1;
    mem_override[32'h418] = 32'hB2;
    mem_override[32'h41C] = 32'hB3;

    #1 rst = 1'b0;
    #3;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("reset_req_ready", 32'(req_ready), 32'd1);

    // Cold miss, hits, conflict.
    apply_stimulus(32'h10, 1'b0, d, h, m);
    check_output("tp_cold_data", d, 32'hA0);
    check_output("tp_cold_hit", 32'(h), 32'd0);
    check_output("tp_cold_mreq_addr", m, 32'h10);
    check_output("tp_cold_miss_cnt", 32'(miss_cnt), 32'd1);
    apply_stimulus(32'h10, 1'b0, d, h, m);
    check_output("tp_rehit_data", d, 32'hA0);
    check_output("tp_rehit_hit", 32'(h), 32'd1);
    apply_stimulus(32'h14, 1'b0, d, h, m);
    check_output("tp_hit14_data", d, 32'hA1);
    check_output("tp_hit14_hit", 32'(h), 32'd1);
    check_output("tp_hit_cnt", 32'(hit_cnt), 32'd2);
    apply_stimulus(32'h410, 1'b0, d, h, m);
    check_output("tp_conflict_data", d, 32'hB0);
    check_output("tp_conflict_hit", 32'(h), 32'd0);
    apply_stimulus(32'h10, 1'b0, d, h, m);
    check_output("tp_evicted_hit", 32'(h), 32'd0);
    check_output("tp_evicted_data", d, 32'hA0);
    check_output("tp_miss_cnt", 32'(miss_cnt), 32'd3);

    // Stalled memory with gaps between beats.
    ready_delay = 5;
    gap_max     = 3;
    apply_stimulus(32'h0000_2028, 1'b0, d, h, m);
    check_output("tp_stall_hit", 32'(h), 32'd0);

    // Flush racing a request; cached line must then miss.
    ready_delay = 0;
    gap_max     = 0;
    apply_stimulus(32'h18, 1'b0, d, h, m);
    check_output("tp_preflush_data", d, 32'hA2);
    check_output("tp_preflush_hit", 32'(h), 32'd1);
    check_output_flush(1'b1, 32'h18);
    apply_stimulus(32'h18, 1'b0, d, h, m);
    check_output("tp_postflush_hit", 32'(h), 32'd0);
    check_output("tp_postflush_data", d, 32'hA2);

    // Randomized traffic over a few tags and indices.
    stray_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ready_delay = $urandom_range(3, 0);
      gap_max     = 2;
      if ($urandom_range(15, 0) == 0) begin
        check_output_flush(1'($urandom_range(1, 0)), $urandom);
      end
      a = {22'($urandom_range(2, 0)), 6'($urandom_range(3, 0)),
           2'($urandom_range(3, 0)), 2'b00};
      apply_stimulus(a, 1'($urandom_range(1, 0)), d, h, m);
    end
    stray_en = 1'b0;

    // Reset after two refill beats.
    ready_delay = 0;
    gap_max     = 1;
    abort_after = 2;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_3008;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 50 && !partial_done; i++) @(negedge clk);
    check_output("partial_refill_reached", 32'(partial_done), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_values("midrefill_reset");
    model_reset();
    abort_after = 4;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("release_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("stray_resp_valid", 32'(resp_valid), 32'd0);
      check_output("stray_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check_output("stray_hit_cnt", 32'(hit_cnt), 32'd0);
      check_output("stray_miss_cnt", 32'(miss_cnt), 32'd0);
    end
    gap_max = 0;
    apply_stimulus(32'h0000_3008, 1'b0, d, h, m);
    check_output("after_reset_hit", 32'(h), 32'd0);

    // Saturation of the hit counter.
    for (int i = 0; i < 1029; i++) begin
      apply_stimulus({28'h0000_300, 2'($urandom_range(3, 0)), 2'b00}, 1'b0, d, h, m);
    end
    check_output("sat_hit_cnt", 32'(hit_cnt), 32'd1023);
    check_output("sat_miss_cnt", 32'(miss_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, read-only cache controller that sequences the cache data BRAM and its tag/valid store. It accepts word reads from the core and performs the tag lookup. On a hit it returns data from the BRAM; on a miss it refills a full line from backing memory before responding. It also keeps hit and miss statistics, and sits between the core fetch/load port and the memory interface.

## Interface
- ADDR_W, 32, request/memory address width
- DATA_W, 32, word width
- INDEX_W, 6, line index bits (64 lines)
- WORD_OFF_W, 2, word-in-line bits (4 words/line)
- CNT_W, 10, statistics counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  core read request
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- req_ready  out  1  controller can accept a request
- flush  in  1  invalidate all lines
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  DATA_W  requested word
- resp_hit  out  1  response was a hit (valid only with resp_valid)
- mem_req_valid  out  1  line-fetch request
- mem_req_addr  out  ADDR_W  line-aligned address (low 2+WORD_OFF_W bits zero)
- mem_req_ready  in  1  memory accepts the fetch
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  DATA_W  refill beat, in word order 0..3
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

## Operation
- Address split: word offset [3:2], index [9:4], tag [31:10]. Tag width = ADDR_W-INDEX_W-WORD_OFF_W-2.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE: req_ready=1. Handshake req_valid&&req_ready latches the address, issues a BRAM read of {index,offset}, and moves to LOOKUP.
- LOOKUP: hit = valid[index] && tag match.
  - Hit: latch the BRAM data, go to RESP with resp_hit=1, hit_cnt+1.
  - Miss: go to MISS_REQ, miss_cnt+1.
- MISS_REQ: hold mem_req_valid=1 and a stable mem_req_addr until mem_req_ready; then go to REFILL with beat counter=0.
- REFILL: each mem_rvalid writes mem_rdata to BRAM {index,beat} and increments beat. The beat equal to the request offset is captured as resp data. After the last beat (beat 3): write tag, set valid, go to RESP with resp_hit=0. No beat limit or timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- flush: acted on only in IDLE. It clears all valid bits in one cycle and forces req_ready=0 that cycle, so flush wins over a simultaneous request. flush in other states is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- mem_rvalid outside REFILL is ignored.

## Timing
- Reset (asynchronous, rst=0): state=IDLE, all valid bits=0, hit_cnt=miss_cnt=0, resp_valid=0, resp_data=0, resp_hit=0, mem_req_valid=0, mem_req_addr=0. req_ready follows IDLE and is 1 once rst=1.
- Reset mid-refill aborts the refill. The line stays invalid; BRAM contents are don't-care.
- Hit latency: request accepted at edge k, resp_valid high in cycle k+2. Back-to-back hits give one request every 3 cycles.
- Miss latency: mem_req_valid rises in cycle k+2. The response comes one cycle after the edge that captures the last refill beat.
- The BRAM is synchronous-read (1-cycle) and single-port. Refill writes and lookups never overlap.
- All outputs are registered except req_ready, which is decoded from state and flush.

## Structure
- Shared cache package: address field widths, the derived TAG_W, and the FSM state encoding.
- One sub-module, cache_data_bram: 2^(INDEX_W+WORD_OFF_W) x DATA_W, synchronous read, one write port. This is the existing BRAM, wrapped with a write enable.
- Tag and valid arrays are flops inside cache_ctrl, so flush clears them in a single cycle.

## Test plan
- Cold miss, read 0x0000_0010, memory returns 0xA0,0xA1,0xA2,0xA3 -> mem_req_addr=0x10, resp_data=0xA0, resp_hit=0, miss_cnt=1.
- Repeat read 0x10, then read 0x14 -> resp_data=0xA0 then 0xA1, both with resp_hit=1 and resp_valid 2 cycles after acceptance; hit_cnt=2.
- Conflict: read 0x410 (same index, different tag), memory returns 0xB0..0xB3 -> miss, resp_data=0xB0. A following read of 0x10 misses again; miss_cnt=3.
- Stall memory: hold mem_req_ready=0 for 5 cycles, then insert gaps between mem_rvalid beats -> mem_req_valid and mem_req_addr stay stable, req_ready=0 throughout, and the correct word is returned.
- flush asserted together with req_valid in IDLE -> request not accepted that cycle. The next read of a previously cached address misses.
- Assert rst=0 after 2 refill beats, then release -> all outputs are at reset values and stray mem_rvalid is ignored. The next read of the same line misses; 2^CNT_W+5 hits leave hit_cnt=2^CNT_W-1.
